ypbpr2rgb_pipe: RTL and testbench

//  Pipelined BT.601 studio-range YPbPr -> RGB converter, 6 bits per component. Inverse of the
//  RGB->YPbPr path: it accepts 6-bit component video, such as external component-in or a loopback
//  of our own encoder output, and produces 6-bit RGB for the scaler / analog RGB path. Sync and

---
 rtl/ypbpr_pkg.sv | 32 +++
 rtl/ypbpr_clamp8.sv | 36 +++
 rtl/ypbpr2rgb_pipe.sv | 165 ++++++++++++++++
 tb/tb_ypbpr2rgb_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ypbpr_pkg.sv
// Shared constants and types for the YPbPr -> RGB converter.
//   K_*    : BT.601 studio-range inverse coefficients, x256 fixed point
//   Y_OFS  : luma black-level offset (8-bit scale)
//   C_OFS  : chroma zero offset (8-bit scale)
//   RND    : rounding constant added before the >>> 8
//   acc_t  : 19-bit signed product / sum type, wide enough that no sum wraps
//   sync_t : hs/vs/de bundle carried alongside the pixel data
package ypbpr_pkg;

    localparam int unsigned K_Y   = 298;
    localparam int unsigned K_RV  = 409;
    localparam int unsigned K_GV  = 208;
    localparam int unsigned K_GU  = 100;
    localparam int unsigned K_BU  = 516;
    localparam int unsigned Y_OFS = 16;
    localparam int unsigned C_OFS = 128;
    localparam int unsigned RND   = 128;

    localparam int unsigned COMP_W = 6;
    localparam int unsigned OFS_W  = 9;
    localparam int unsigned ACC_W  = 19;
    localparam int unsigned CNT_W  = 16;

    typedef logic signed [ACC_W-1:0] acc_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

endpackage

// File: rtl/ypbpr_clamp8.sv
// Per-channel saturation of a x256 fixed-point result to 8 bits, returning the
// upper 6 bits of the clamped value plus a flag when clamping took place.
//   i_acc    : rounded sum (value x256), signed
//   o_val_c  : clamp(i_acc >>> 8)[7:2], combinational
//   o_clip_c : 1 when the value was below 0 or above 255, combinational
module ypbpr_clamp8
    import ypbpr_pkg::*;
(
    input  acc_t        i_acc,
    output logic [5:0]  o_val_c,
    output logic        o_clip_c
);

    logic w_neg;
    logic w_over;
    logic w_unused_frac;

    // (i_acc >>> 8) is negative iff the sign bit is set, and exceeds 255 iff
    // any of bits [17:16] is set on a positive value; bits [15:8] are the
    // in-range 8-bit result, so only [15:10] reach the output.
    assign w_neg         = i_acc[18];
    assign w_over        = ~i_acc[18] & (|i_acc[17:16]);
    assign w_unused_frac = ^i_acc[9:0];

    always_comb begin
        o_val_c = i_acc[15:10];
        if (w_neg) begin
            o_val_c = '0;
        end else if (w_over) begin
            o_val_c = '1;
        end
    end

    assign o_clip_c = w_neg | w_over;

endmodule

// File: rtl/ypbpr2rgb_pipe.sv
// Pipelined BT.601 studio-range YPbPr -> RGB converter, 6 bits per component.
// Three pipeline stages, each advancing only on ce_pix; hs/vs/de follow in a
// matching 3-deep delay so they stay aligned with the RGB data.
// Optional feature macro: YPBPR2RGB_CLIPSTAT_EN adds a per-frame clip counter.
// Ports:
//   clk_sys, reset       : clock, synchronous active-high reset
//   ce_pix               : pixel clock enable
//   y, pb, pr            : 6-bit components (8-bit value = {x,2'b00})
//   hs_in, vs_in, de_in  : sync and display enable in
//   red, green, blue     : 6-bit RGB out (0 when aligned de = 0)
//   hs_out, vs_out, de_out : sync and display enable aligned to RGB
//   clip                 : at least one channel of this pixel saturated
//   clip_count           : (macro only) clipped pixels in the previous frame
module ypbpr2rgb_pipe
    import ypbpr_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic [5:0]  y,
    input  logic [5:0]  pb,
    input  logic [5:0]  pr,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        de_in,
    output logic [5:0]  red,
    output logic [5:0]  green,
    output logic [5:0]  blue,
    output logic        hs_out,
    output logic        vs_out,
    output logic        de_out,
    output logic        clip
`ifdef YPBPR2RGB_CLIPSTAT_EN
    ,
    output logic [15:0] clip_count
`endif
);

    // Offset removal (combinational, feeds S1)
    logic signed [OFS_W-1:0] w_ys;
    logic signed [OFS_W-1:0] w_cbs;
    logic signed [OFS_W-1:0] w_crs;

    assign w_ys  = {1'b0, y,  2'b00} - OFS_W'(Y_OFS);
    assign w_cbs = {1'b0, pb, 2'b00} - OFS_W'(C_OFS);
    assign w_crs = {1'b0, pr, 2'b00} - OFS_W'(C_OFS);

    // S1: offset-removed components and sync
    logic signed [OFS_W-1:0] r_ys;
    logic signed [OFS_W-1:0] r_cbs;
    logic signed [OFS_W-1:0] r_crs;
    sync_t                   r_sync1;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_ys    <= '0;
            r_cbs   <= '0;
            r_crs   <= '0;
            r_sync1 <= '0;
        end else if (ce_pix) begin
            r_ys    <= w_ys;
            r_cbs   <= w_cbs;
            r_crs   <= w_crs;
            r_sync1 <= '{hs: hs_in, vs: vs_in, de: de_in};
        end
    end

    // S2: the five products
    acc_t  r_py;
    acc_t  r_prv;
    acc_t  r_pgv;
    acc_t  r_pgu;
    acc_t  r_pbu;
    sync_t r_sync2;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_py    <= '0;
            r_prv   <= '0;
            r_pgv   <= '0;
            r_pgu   <= '0;
            r_pbu   <= '0;
            r_sync2 <= '0;
        end else if (ce_pix) begin
            r_py    <= acc_t'(r_ys)  * acc_t'(K_Y);
            r_prv   <= acc_t'(r_crs) * acc_t'(K_RV);
            r_pgv   <= acc_t'(r_crs) * acc_t'(K_GV);
            r_pgu   <= acc_t'(r_cbs) * acc_t'(K_GU);
            r_pbu   <= acc_t'(r_cbs) * acc_t'(K_BU);
            r_sync2 <= r_sync1;
        end
    end

    // Sums and clamp (combinational, feeds S3)
    acc_t       w_sum_r;
    acc_t       w_sum_g;
    acc_t       w_sum_b;
    logic [5:0] w_r_val;
    logic [5:0] w_g_val;
    logic [5:0] w_b_val;
    logic       w_r_clip;
    logic       w_g_clip;
    logic       w_b_clip;
    logic       w_clip_pix;

    assign w_sum_r = r_py + r_prv + acc_t'(RND);
    assign w_sum_g = r_py - r_pgv - r_pgu + acc_t'(RND);
    assign w_sum_b = r_py + r_pbu + acc_t'(RND);

    ypbpr_clamp8 u_clamp_r (.i_acc(w_sum_r), .o_val_c(w_r_val), .o_clip_c(w_r_clip));
    ypbpr_clamp8 u_clamp_g (.i_acc(w_sum_g), .o_val_c(w_g_val), .o_clip_c(w_g_clip));
    ypbpr_clamp8 u_clamp_b (.i_acc(w_sum_b), .o_val_c(w_b_val), .o_clip_c(w_b_clip));

    // Blanked pixels still saturate internally but never report a clip
    assign w_clip_pix = r_sync2.de & (w_r_clip | w_g_clip | w_b_clip);

    // S3: output registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            red    <= '0;
            green  <= '0;
            blue   <= '0;
            hs_out <= 1'b0;
            vs_out <= 1'b0;
            de_out <= 1'b0;
            clip   <= 1'b0;
        end else if (ce_pix) begin
            red    <= r_sync2.de ? w_r_val : 6'd0;
            green  <= r_sync2.de ? w_g_val : 6'd0;
            blue   <= r_sync2.de ? w_b_val : 6'd0;
            hs_out <= r_sync2.hs;
            vs_out <= r_sync2.vs;
            de_out <= r_sync2.de;
            clip   <= w_clip_pix;
        end
    end

`ifdef YPBPR2RGB_CLIPSTAT_EN
    // Per-frame clip statistics, latched on each rising edge of vs_out
    logic [CNT_W-1:0] r_clip_cnt;
    logic             r_vs_d;
    logic             w_vs_rise;
    logic             w_clip_ev;

    assign w_vs_rise = vs_out & ~r_vs_d;
    assign w_clip_ev = ce_pix & w_clip_pix;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_clip_cnt <= '0;
            r_vs_d     <= 1'b0;
            clip_count <= '0;
        end else begin
            r_vs_d <= vs_out;
            if (w_vs_rise) begin
                clip_count <= r_clip_cnt;
                r_clip_cnt <= CNT_W'(w_clip_ev);
            end else if (w_clip_ev && (r_clip_cnt != '1)) begin
                r_clip_cnt <= r_clip_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ypbpr2rgb_pipe.sv
// Self-checking bench for ypbpr2rgb_pipe: a behavioural model (plain integer
// BT.601 arithmetic plus a pixel queue) is compared against the DUT on every
// cycle, and hand-computed vectors pin both the DUT and the model.
module tb_ypbpr2rgb_pipe;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic       ce_pix  = 1'b0;
    logic [5:0] y       = '0;
    logic [5:0] pb      = '0;
    logic [5:0] pr      = '0;
    logic       hs_in   = 1'b0;
    logic       vs_in   = 1'b0;
    logic       de_in   = 1'b0;
    logic [5:0] red;
    logic [5:0] green;
    logic [5:0] blue;
    logic       hs_out;
    logic       vs_out;
    logic       de_out;
    logic       clip;
`ifdef YPBPR2RGB_CLIPSTAT_EN
    logic [15:0] clip_count;
`endif

    int checks = 0;
    int errors = 0;

    ypbpr2rgb_pipe dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .ce_pix (ce_pix),
        .y      (y),
        .pb     (pb),
        .pr     (pr),
        .hs_in  (hs_in),
        .vs_in  (vs_in),
        .de_in  (de_in),
        .red    (red),
        .green  (green),
        .blue   (blue),
        .hs_out (hs_out),
        .vs_out (vs_out),
        .de_out (de_out),
        .clip   (clip)
`ifdef YPBPR2RGB_CLIPSTAT_EN
        ,
        .clip_count(clip_count)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [5:0] r;
        logic [5:0] g;
        logic [5:0] b;
        logic       hs;
        logic       vs;
        logic       de;
        logic       clip;
    } pix_t;

    function automatic int sat8(input int v);
        if (v < 0)   return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    // Expected output pixel for one input sample, straight from the formulas
    function automatic pix_t model_pix(input logic [5:0] yy, input logic [5:0] pbv,
                                       input logic [5:0] prv, input logic h,
                                       input logic v, input logic d);
        int   ys;
        int   cbs;
        int   crs;
        int   rr;
        int   gg;
        int   bb;
        logic cl;
        pix_t p;
        ys  = int'(yy)  * 4 - 16;
        cbs = int'(pbv) * 4 - 128;
        crs = int'(prv) * 4 - 128;
        rr  = (298 * ys + 409 * crs + 128) >>> 8;
        gg  = (298 * ys - 208 * crs - 100 * cbs + 128) >>> 8;
        bb  = (298 * ys + 516 * cbs + 128) >>> 8;
        cl  = (sat8(rr) != rr) || (sat8(gg) != gg) || (sat8(bb) != bb);
        p.r    = d ? 6'(sat8(rr) / 4) : 6'd0;
        p.g    = d ? 6'(sat8(gg) / 4) : 6'd0;
        p.b    = d ? 6'(sat8(bb) / 4) : 6'd0;
        p.hs   = h;
        p.vs   = v;
        p.de   = d;
        p.clip = d & cl;
        return p;
    endfunction

    // Model state: queue holds the two pixels in flight ahead of the output
    pix_t q[$];
    pix_t exp_o   = '0;
    pix_t act_o;
    logic chk_en  = 1'b0;
`ifdef YPBPR2RGB_CLIPSTAT_EN
    logic [15:0] m_cnt  = '0;
    logic [15:0] m_cc   = '0;
    logic        m_vs_d = 1'b0;
    logic        m_rise;
    logic        m_ev;
`endif

    always @(posedge clk_sys) begin
        if (reset) begin
            q.delete();
            q.push_back(pix_t'(0));
            q.push_back(pix_t'(0));
            exp_o  = '0;
            chk_en = 1'b1;
`ifdef YPBPR2RGB_CLIPSTAT_EN
            m_cnt  = '0;
            m_cc   = '0;
            m_vs_d = 1'b0;
`endif
        end else begin
`ifdef YPBPR2RGB_CLIPSTAT_EN
            m_rise = exp_o.vs & ~m_vs_d;
            m_ev   = ce_pix & q[0].clip;
            m_vs_d = exp_o.vs;
            if (m_rise) begin
                m_cc  = m_cnt;
                m_cnt = m_ev ? 16'd1 : 16'd0;
            end else if (m_ev && m_cnt != 16'hFFFF) begin
                m_cnt = m_cnt + 16'd1;
            end
`endif
            if (ce_pix) begin
                exp_o = q.pop_front();
                q.push_back(model_pix(y, pb, pr, hs_in, vs_in, de_in));
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk_sys) begin
        if (chk_en) begin
            act_o = {red, green, blue, hs_out, vs_out, de_out, clip};
            checks++;
            if (act_o !== exp_o) begin
                errors++;
                $display("FAIL pixel t=%0t got rgb=%0d,%0d,%0d hs=%b vs=%b de=%b clip=%b need rgb=%0d,%0d,%0d hs=%b vs=%b de=%b clip=%b",
                         $time, red, green, blue, hs_out, vs_out, de_out, clip,
                         exp_o.r, exp_o.g, exp_o.b, exp_o.hs, exp_o.vs, exp_o.de, exp_o.clip);
            end
`ifdef YPBPR2RGB_CLIPSTAT_EN
            checks++;
            if (clip_count !== m_cc) begin
                errors++;
                $display("FAIL clip_count t=%0t got %0d need %0d", $time, clip_count, m_cc);
            end
`endif
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] need);
        checks++;
        if (got !== need) begin
            errors++;
            $display("FAIL %s got %0d need %0d", nm, got, need);
        end
    endtask

    // Hold one vector for 3 ce pulses and compare DUT and model to literals
    task automatic lit(input string nm, input logic [5:0] yy, input logic [5:0] pbv,
                       input logic [5:0] prv, input logic [5:0] er, input logic [5:0] eg,
                       input logic [5:0] eb, input logic ec);
        pix_t m;
        @(negedge clk_sys);
        ce_pix = 1'b1; y = yy; pb = pbv; pr = prv;
        hs_in = 1'b0; vs_in = 1'b0; de_in = 1'b1;
        repeat (3) @(negedge clk_sys);
        chk({nm, "_dut"}, {red, green, blue, clip}, {er, eg, eb, ec});
        m = model_pix(yy, pbv, prv, 1'b0, 1'b0, 1'b1);
        chk({nm, "_model"}, {m.r, m.g, m.b, m.clip}, {er, eg, eb, ec});
    endtask

    initial begin
        repeat (2) @(negedge clk_sys);
        chk("reset_state", {red, green, blue, hs_out, vs_out, de_out, clip}, '0);
        reset = 1'b0;

        lit("black",     6'd4,  6'd32, 6'd32, 6'd0,  6'd0,  6'd0,  1'b0);
        lit("grey",      6'd58, 6'd32, 6'd32, 6'd62, 6'd62, 6'd62, 1'b0);
        lit("white_sat", 6'd63, 6'd32, 6'd32, 6'd63, 6'd63, 6'd63, 1'b1);
        lit("red_cr",    6'd4,  6'd32, 6'd63, 6'd49, 6'd0,  6'd0,  1'b1);
        lit("low_cb",    6'd32, 6'd0,  6'd32, 6'd32, 6'd45, 6'd0,  1'b1);

        // Sparse enable: ce every 4th clock with a sync/de pattern
        for (int c = 0; c < 240; c++) begin
            @(negedge clk_sys);
            ce_pix = (c % 4 == 0);
            y  = 6'($urandom);
            pb = 6'($urandom);
            pr = 6'($urandom);
            hs_in = ((c / 4) % 16) < 2;
            vs_in = ((c / 4) % 40) < 3;
            de_in = ((c / 4) % 8) > 1;
        end

        // Reset mid-stream, then first new output on the 3rd ce pulse
        @(negedge clk_sys);
        ce_pix = 1'b1; y = 6'd58; pb = 6'd32; pr = 6'd32;
        hs_in = 1'b1; vs_in = 1'b0; de_in = 1'b1;
        @(negedge clk_sys);
        reset = 1'b1;
        @(negedge clk_sys);
        chk("mid_reset_zero", {red, green, blue, hs_out, vs_out, de_out, clip}, '0);
        reset = 1'b0;
        repeat (2) @(negedge clk_sys);
        chk("after_reset_2ce", {red, de_out}, {6'd0, 1'b0});
        @(negedge clk_sys);
        chk("after_reset_3ce", {red, green, blue, de_out}, {6'd62, 6'd62, 6'd62, 1'b1});

`ifdef YPBPR2RGB_CLIPSTAT_EN
        // Ten clipped pixels in a frame, then vs rises
        hs_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys);
            y = 6'd63; pb = 6'd32; pr = 6'd32; vs_in = 1'b0; de_in = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_sys);
            y = 6'd4; vs_in = 1'b1;
        end
        @(negedge clk_sys);
        chk("clip_count_10", 32'(clip_count), 32'd10);
`endif

        // Randomized traffic with random enable and occasional resets
        for (int c = 0; c < 800; c++) begin
            @(negedge clk_sys);
            reset  = ($urandom_range(0, 149) == 0);
            ce_pix = ($urandom_range(0, 3) != 0);
            y  = 6'($urandom);
            pb = 6'($urandom);
            pr = 6'($urandom);
            hs_in = ($urandom_range(0, 9) == 0);
            vs_in = ((c % 60) < 4);
            de_in = ($urandom_range(0, 4) != 0);
        end

        @(negedge clk_sys);
        reset = 1'b0;
        ce_pix = 1'b0;
        repeat (2) @(negedge clk_sys);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
